// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, start bit, 8 data bits LSB-first, odd parity,
// stop bit and device acknowledge, with both pads driven low through open-drain output enables.
module ps2_host_tx #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       fpgaclk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       ps2clk,
    input  logic       datain,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);
    localparam int CNT_SPAN = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CW = $clog2(CNT_SPAN + 1);
    localparam logic [CW-1:0] CNT_MAX      = '1;
    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    if (CLK_HZ <= 0 || INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_host_tx: CLK_HZ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    typedef enum logic [2:0] {IDLE, INHIBIT, START, XMIT, ACK, WAITIDLE} state_t;

    state_t        state, state_nxt;
    logic          clk_s1, clk_s2, clk_prev, data_s1, data_s2;
    logic          fall;
    logic [CW-1:0] count, count_nxt, count_inc;
    logic [3:0]    bitcnt, bitcnt_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          par, par_nxt;
    logic          clk_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, err_nxt;

    // Pads idle high, so the synchronizers reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge fpgaclk) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
        end else begin
            clk_s1   <= ps2clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= datain;
            data_s2  <= data_s1;
        end
    end

    assign fall      = clk_prev & ~clk_s2;
    assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;

    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        bitcnt_nxt  = bitcnt;
        shift_nxt   = shift;
        par_nxt     = par;
        clk_oe_nxt  = ps2clk_oe;
        data_oe_nxt = ps2data_oe;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: begin
                clk_oe_nxt  = 1'b0;
                data_oe_nxt = 1'b0;
                busy_nxt    = 1'b0;
                if (tx_start) begin
                    state_nxt  = INHIBIT;
                    count_nxt  = '0;
                    clk_oe_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                    shift_nxt  = tx_data;
                    par_nxt    = ~^tx_data;
                    bitcnt_nxt = '0;
                end
            end
            INHIBIT: begin
                count_nxt = count_inc;
                if (count == INHIBIT_LAST) begin
                    data_oe_nxt = 1'b1;
                    state_nxt   = START;
                end
            end
            START: begin
                clk_oe_nxt = 1'b0;
                count_nxt  = '0;
                state_nxt  = XMIT;
            end
            // Every device-clocked state shares one watchdog that restarts on each falling edge.
            XMIT, ACK, WAITIDLE: begin
                count_nxt = fall ? '0 : count_inc;
                if (!fall && count == TIMEOUT_LAST) begin
                    clk_oe_nxt  = 1'b0;
                    data_oe_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end else if (state == XMIT) begin
                    if (fall) begin
                        bitcnt_nxt = bitcnt + 4'd1;
                        if (bitcnt < 4'd8) begin
                            data_oe_nxt = ~shift[0];
                            shift_nxt   = {1'b0, shift[7:1]};
                        end else if (bitcnt == 4'd8) begin
                            data_oe_nxt = ~par;
                        end else begin
                            data_oe_nxt = 1'b0;
                            state_nxt   = ACK;
                        end
                    end
                end else if (state == ACK) begin
                    if (fall) begin
                        if (data_s2) begin
                            err_nxt   = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = WAITIDLE;
                        end
                    end
                end else if (clk_s2 && data_s2) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fpgaclk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            bitcnt     <= '0;
            shift      <= '0;
            par        <= 1'b0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            bitcnt     <= bitcnt_nxt;
            shift      <= shift_nxt;
            par        <= par_nxt;
            ps2clk_oe  <= clk_oe_nxt;
            ps2data_oe <= data_oe_nxt;
            busy       <= busy_nxt;
            tx_done    <= done_nxt;
            tx_err     <= err_nxt;
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a scaled-down PS/2 device drives the pads while an event schedule,
// built from the frame timing rules, predicts every output on every cycle.
module tb_ps2_host_tx;
    localparam int N    = 20;
    localparam int TO   = 100;
    localparam int HALF = 12;
    localparam int LEAD = 10;
    localparam int SIG_CLK = 0, SIG_DATA = 1, SIG_BUSY = 2, SIG_DONE = 3, SIG_ERR = 4;
    localparam int MODE_ACK = 0, MODE_NOACK = 1, MODE_SILENT = 2, MODE_RESET = 3;

    logic       fpgaclk, rst, tx_start;
    logic [7:0] tx_data;
    logic       ps2clk, datain;
    logic       ps2clk_oe, ps2data_oe, busy, tx_done, tx_err;
    logic       dev_clk, dev_data;

    assign ps2clk = dev_clk & ~ps2clk_oe;
    assign datain = dev_data & ~ps2data_oe;

    ps2_host_tx #(
        .CLK_HZ(50_000_000),
        .INHIBIT_CYCLES(N),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .fpgaclk(fpgaclk),
        .rst(rst),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .ps2clk(ps2clk),
        .datain(datain),
        .ps2clk_oe(ps2clk_oe),
        .ps2data_oe(ps2data_oe),
        .busy(busy),
        .tx_done(tx_done),
        .tx_err(tx_err)
    );

    initial fpgaclk = 1'b0;
    always #5 fpgaclk = ~fpgaclk;

    typedef struct {
        int at;
        int sig;
        bit val;
    } ev_t;

    ev_t        evq[$];
    int         edge_n;
    bit         exp_clk_oe, exp_data_oe, exp_busy, exp_done, exp_err;
    int         checks, errors;
    int         done_cnt, err_cnt, clk_hi_cnt, overlap_cnt, err_edge, start_exit;
    logic [9:0] cap;

    task automatic sched(input int at, input int sig, input bit val);
        ev_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        evq.push_back(e);
    endtask

    task automatic set_exp(input int sig, input bit v);
        case (sig)
            SIG_CLK:  exp_clk_oe  = v;
            SIG_DATA: exp_data_oe = v;
            SIG_BUSY: exp_busy    = v;
            SIG_DONE: exp_done    = v;
            SIG_ERR:  exp_err     = v;
            default:  ;
        endcase
    endtask

    task automatic apply_sched();
        ev_t keep[$];
        foreach (evq[i]) begin
            if (evq[i].at == edge_n) set_exp(evq[i].sig, evq[i].val);
            else keep.push_back(evq[i]);
        end
        evq = keep;
    endtask

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %b expected %b", name, edge_n, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput();
        cmp("ps2clk_oe", ps2clk_oe, exp_clk_oe);
        cmp("ps2data_oe", ps2data_oe, exp_data_oe);
        cmp("busy", busy, exp_busy);
        cmp("tx_done", tx_done, exp_done);
        cmp("tx_err", tx_err, exp_err);
        if (tx_done === 1'b1) done_cnt++;
        if (tx_err === 1'b1) begin
            err_cnt++;
            if (err_edge < 0) err_edge = edge_n;
        end
        if (ps2clk_oe === 1'b1) clk_hi_cnt++;
        if (ps2clk_oe === 1'b1 && ps2data_oe === 1'b1) overlap_cnt++;
    endtask

    task automatic tick();
        @(posedge fpgaclk);
        edge_n++;
        apply_sched();
        @(negedge fpgaclk);
        checkOutput();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // One whole host request; pad changes land between edges, so outputs follow 3 edges later.
    task automatic applyStimulus(input logic [7:0] b, input int mode, input logic [7:0] intruder);
        int e, s, p, q;
        done_cnt = 0; err_cnt = 0; clk_hi_cnt = 0; overlap_cnt = 0; err_edge = -1; cap = '0;
        e = edge_n + 1;
        s = e + N + 1;
        start_exit = s;
        sched(e, SIG_CLK, 1'b1);
        sched(e, SIG_BUSY, 1'b1);
        sched(e + N, SIG_DATA, 1'b1);
        sched(s, SIG_CLK, 1'b0);
        tx_data = b; tx_start = 1'b1;
        tick();
        tx_start = 1'b0; tx_data = 8'h00;
        if (mode == MODE_SILENT) begin
            sched(s + TO, SIG_DATA, 1'b0);
            sched(s + TO, SIG_BUSY, 1'b0);
            sched(s + TO, SIG_ERR, 1'b1);
            sched(s + TO + 1, SIG_ERR, 1'b0);
            while (edge_n < s + TO + 5) tick();
            return;
        end
        while (edge_n < s + LEAD) tick();
        for (int k = 1; k <= 11; k++) begin
            p = edge_n;
            dev_clk = 1'b0;
            if (k <= 8) sched(p + 3, SIG_DATA, ~b[k-1]);
            else if (k == 9) sched(p + 3, SIG_DATA, ^b);
            else if (k == 10) sched(p + 3, SIG_DATA, 1'b0);
            else if (mode == MODE_NOACK) begin
                sched(p + 3, SIG_ERR, 1'b1);
                sched(p + 4, SIG_ERR, 1'b0);
                sched(p + 3, SIG_BUSY, 1'b0);
            end
            ticks(3);
            if (k <= 10) cap[k-1] = ps2data_oe;
            if (mode == MODE_RESET && k == 5) begin
                evq.delete();
                for (int sg = SIG_CLK; sg <= SIG_ERR; sg++) sched(edge_n + 1, sg, 1'b0);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                dev_clk = 1'b1;
                ticks(10);
                return;
            end
            if (mode == MODE_RESET && k == 2) begin
                tx_data = intruder; tx_start = 1'b1;
                tick();
                tx_start = 1'b0; tx_data = 8'h00;
                ticks(HALF - 4);
            end else begin
                ticks(HALF - 3);
            end
            q = edge_n;
            dev_clk = 1'b1;
            if (k == 10 && mode == MODE_ACK) dev_data = 1'b0;
            if (k == 11) begin
                dev_data = 1'b1;
                if (mode == MODE_ACK) begin
                    sched(q + 3, SIG_DONE, 1'b1);
                    sched(q + 4, SIG_DONE, 1'b0);
                    sched(q + 3, SIG_BUSY, 1'b0);
                end
            end
            ticks(HALF);
        end
    endtask

    initial begin
        rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
        edge_n = 0; checks = 0; errors = 0;
        exp_clk_oe = 1'b0; exp_data_oe = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
        ticks(3);
        rst = 1'b0;
        ticks(5);

        applyStimulus(8'hED, MODE_ACK, 8'h00);
        checkInt("ed_data_oe_pattern", int'(cap), 'h012);
        checkInt("ed_done_pulses", done_cnt, 1);
        ticks(5);

        applyStimulus(8'hF4, MODE_ACK, 8'h00);
        checkInt("f4_data_oe_pattern", int'(cap), 'h10B);
        checkInt("f4_done_pulses", done_cnt, 1);
        ticks(5);

        applyStimulus(8'h00, MODE_ACK, 8'h00);
        checkInt("zero_data_oe_pattern", int'(cap), 'h0FF);
        checkInt("zero_clk_oe_cycles", clk_hi_cnt, N + 1);
        checkInt("zero_oe_overlap", overlap_cnt, 1);
        ticks(5);

        applyStimulus(8'hA5, MODE_SILENT, 8'h00);
        checkInt("timeout_err_offset", err_edge - start_exit, 100);
        checkInt("timeout_err_pulses", err_cnt, 1);
        checkInt("timeout_done_pulses", done_cnt, 0);
        ticks(5);

        applyStimulus(8'h3C, MODE_NOACK, 8'h00);
        checkInt("noack_err_pulses", err_cnt, 1);
        checkInt("noack_done_pulses", done_cnt, 0);
        ticks(5);

        applyStimulus(8'hF4, MODE_ACK, 8'h00);
        checkInt("retry_f4_pattern", int'(cap), 'h10B);
        checkInt("retry_f4_done_pulses", done_cnt, 1);
        ticks(5);

        applyStimulus(8'hED, MODE_RESET, 8'h5A);
        checkInt("reset_frame_first_bits", int'(cap[4:0]), 18);
        checkInt("reset_frame_done_pulses", done_cnt, 0);
        ticks(5);

        applyStimulus(8'h96, MODE_ACK, 8'h00);
        checkInt("post_reset_96_pattern", int'(cap), 'h069);
        checkInt("post_reset_96_done", done_cnt, 1);
        ticks(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard over the same two open-drain lines the scancode receive path listens on. It runs the full host request sequence: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit, and device acknowledge check. Each pad is driven through an output-enable that pulls the line low, so the receive path keeps sampling the same pads unchanged.

## Interface
- CLK_HZ, 50_000_000, fpgaclk frequency; documentation only.
- INHIBIT_CYCLES, 5000, fpgaclk cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000, maximum fpgaclk cycles allowed between consecutive ps2clk falling edges, and before the first one (15 ms).

- fpgaclk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- tx_start  in  1  one-cycle request; accepted only when busy=0.
- tx_data  in  8  byte to send; sampled on the cycle tx_start is accepted.
- ps2clk  in  1  PS/2 clock pad value (asynchronous).
- datain  in  1  PS/2 data pad value (asynchronous).
- ps2clk_oe  out  1  1 = pull clock pad low.
- ps2data_oe  out  1  1 = pull data pad low.
- busy  out  1  high from the cycle after acceptance until the cycle the done or error pulse fires.
- tx_done  out  1  one-cycle pulse: frame sent and acknowledged.
- tx_err  out  1  one-cycle pulse: timeout or missing acknowledge.

## Operation
- ps2clk and datain each pass through a 2-flop synchronizer. A falling edge ("fall") is sync_prev=1 and sync_now=0.
- Latch: on acceptance, store shift = tx_data and par = ~^tx_data (odd parity). Set bitcnt = 0.
- States:
  - IDLE: both oe = 0. tx_start → INHIBIT. Clear the counter, set ps2clk_oe=1.
  - INHIBIT: ps2clk_oe=1. When counter = INHIBIT_CYCLES-1, set ps2data_oe=1 (start bit 0) → START.
  - START: ps2clk_oe=1, ps2data_oe=1 for exactly 1 cycle. Then ps2clk_oe=0 → XMIT, clearing the timeout counter.
  - XMIT: on each fall, increment bitcnt and drive the next bit. Falls 1–8 drive data bits 0–7; fall 9 drives parity; fall 10 drives stop (ps2data_oe=0) → ACK. For a bit value b, ps2data_oe = ~b.
  - ACK: on the next fall, sample synchronized datain. Value 0 → WAITIDLE. Value 1 → tx_err pulse, → IDLE.
  - WAITIDLE: when synchronized ps2clk=1 and datain=1, fire the tx_done pulse → IDLE.
- Timeout: in XMIT, ACK and WAITIDLE, count cycles since the last fall (since START exit for the first). Reaching TIMEOUT_CYCLES releases both lines, fires the tx_err pulse, → IDLE.
- tx_start while busy=1 is ignored; no queueing.
- Reset: IDLE, and both oe, busy, tx_done and tx_err go to 0. A reset mid-frame releases the lines on the next edge.

## Timing
- Output reset values: ps2clk_oe=0, ps2data_oe=0, busy=0, tx_done=0, tx_err=0.
- ps2clk_oe rises the cycle after tx_start is accepted. It stays high for INHIBIT_CYCLES+1 cycles.
- ps2data_oe rises INHIBIT_CYCLES cycles after ps2clk_oe rises, and overlaps it by exactly 1 cycle.
- Each data/parity/stop update lands 3 fpgaclk cycles after the ps2clk pad falls: 2 synchronizer cycles plus 1 register cycle. That is well inside the ~30 µs low phase.
- tx_done/tx_err fire 3 cycles after the qualifying pad event, and busy falls in the same cycle. A new tx_start is accepted the following cycle.
- All outputs are registered. Counter width is ≥ clog2(TIMEOUT_CYCLES+1). Both counters saturate and do not wrap.

## Test plan
- Send 0xED; the device model clocks at 12 kHz and acks. Required: data line low for bits 1,0,1,1,0,1,1,1 inverted per oe rule, then parity 1 (oe=0), stop released, tx_done single pulse, busy low.
- Send 0xF4. Required: LSB-first 0,0,1,0,1,1,1,1, parity 0 (oe=1 during parity), tx_done.
- Send 0x00 with INHIBIT_CYCLES=20. Required: ps2clk_oe high exactly 21 cycles, a 1-cycle overlap with ps2data_oe, and parity bit 1.
- Device model never clocks, TIMEOUT_CYCLES=100. Required: tx_err pulse 100 cycles after START exit, both oe=0, no tx_done.
- Device model leaves data high at the ack clock. Required: tx_err pulse, no tx_done. Then tx_start 0xF4 succeeds normally.
- Assert rst at bit 4 of a frame. Required: both oe=0 and busy=0 on the next edge. A pulse on tx_start while busy (before reset) is ignored, so transmitted bits still match the first byte.
